// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_controller
// Description : Multiplexed seven-segment scanner with frame-aligned two-page
//               display, per-digit blinking and registered outputs.
//               Optional leading-zero blanking when SSD_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  page_sel,
    input  logic [4*DIGITS-1:0]   bcd_a,
    input  logic [4*DIGITS-1:0]   bcd_b,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     ssd_ctrl,
    output logic [6:0]            show,
    output logic                  frame_done
);

    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_PS_W  = $clog2(PRESCALE);
    localparam int c_BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [c_PS_W-1:0]  c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam logic [c_BF_W-1:0]  c_BF_LAST  = c_BF_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]         c_SEG_OFF  = 7'b1111111;

    logic [c_PS_W-1:0]   r_presc;
    logic [c_IDX_W-1:0]  r_index;
    logic                r_page;
    logic [c_BF_W-1:0]   r_bcnt;
    logic                r_phase;
    logic                r_frame_done;
    logic [DIGITS-1:0]   r_ssd_ctrl;
    logic [6:0]          r_show;

    logic                w_tick;
    logic                w_frame_end;
    logic [4*DIGITS-1:0] w_page_bcd;
    logic [3:0]          w_digit;
    logic                w_blink_sel;
    logic                w_lz_blank;
    logic [DIGITS-1:0]   w_ctrl_next;
    logic [6:0]          w_show_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    assign w_tick      = en && (r_presc == c_PS_LAST);
    assign w_frame_end = w_tick && (r_index == c_IDX_LAST);
    assign w_page_bcd  = r_page ? bcd_b : bcd_a;

    // Scan/page/blink state; the page only changes on a frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_index      <= '0;
            r_page       <= 1'b0;
            r_bcnt       <= '0;
            r_phase      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (en) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                r_index <= (r_index == c_IDX_LAST) ? '0 : r_index + 1'b1;
            end
            if (w_frame_end) begin
                r_page <= page_sel;
                if (r_bcnt == c_BF_LAST) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt  <= r_bcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_digit     = 4'd0;
        w_blink_sel = 1'b0;
        w_ctrl_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_index == c_IDX_W'(i)) begin
                w_digit        = w_page_bcd[4*i +: 4];
                w_blink_sel    = blink_mask[i];
                w_ctrl_next[i] = 1'b0;
            end
        end
    end

`ifdef SSD_LZB_EN
    // Running "everything from here upward is zero" flag, top digit down
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_lz_blank   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero_above = v_zero_above && (w_page_bcd[4*i +: 4] == 4'd0);
            if (r_index == c_IDX_W'(i)) begin
                w_lz_blank = v_zero_above;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_show_next = seg_decode(w_digit);
        if ((w_blink_sel && !r_phase) || w_lz_blank) begin
            w_show_next = c_SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ssd_ctrl <= '1;
            r_show     <= c_SEG_OFF;
        end else if (!en) begin
            r_ssd_ctrl <= '1;
            r_show     <= c_SEG_OFF;
        end else begin
            r_ssd_ctrl <= w_ctrl_next;
            r_show     <= w_show_next;
        end
    end

    assign ssd_ctrl   = r_ssd_ctrl;
    assign show       = r_show;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_controller
// Description : Self-checking bench for ssd_scan_controller against a
//               cycle-count based reference model (DIGITS=4, PRESCALE=4, BF=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = PRESCALE * DIGITS;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                page_sel = 1'b0;
    logic [4*DIGITS-1:0] bcd_a = '0;
    logic [4*DIGITS-1:0] bcd_b = '0;
    logic [DIGITS-1:0]   blink_mask = '0;
    logic [DIGITS-1:0]   ssd_ctrl;
    logic [6:0]          show;
    logic                frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Model state: enabled cycles since reset, and the page shown this frame
    int n = 0;
    bit mpage = 1'b0;

    ssd_scan_controller #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .page_sel   (page_sel),
        .bcd_a      (bcd_a),
        .bcd_b      (bcd_b),
        .blink_mask (blink_mask),
        .ssd_ctrl   (ssd_ctrl),
        .show       (show),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] model_show(input int nn, input bit pg,
                                              input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] m);
        int idx;
        int frame;
        bit visible;
        bit lead_zero;
        logic [15:0] act;
        idx     = (nn / PRESCALE) % DIGITS;
        frame   = nn / FRAME_CYC;
        visible = ((frame / BLINK_FRAMES) % 2) == 0;
        act     = pg ? b : a;
        if (m[idx] && !visible) return 7'b1111111;
        lead_zero = 1'b1;
        for (int j = DIGITS - 1; j >= idx; j--) begin
            if (act[4*j +: 4] != 4'd0) lead_zero = 1'b0;
        end
`ifdef SSD_LZB_EN
        if (idx >= 1 && lead_zero) return 7'b1111111;
`endif
        return seg_of(act[4*idx +: 4]);
    endfunction

    // One clock of stimulus: predict from pre-edge state and inputs, then compare
    task automatic step(input string tag);
        logic [3:0] e_ctrl;
        logic [6:0] e_show;
        logic       e_fd;
        logic       en_pre;
        logic       ps_pre;
        int         idx;
        idx    = (n / PRESCALE) % DIGITS;
        en_pre = en;
        ps_pre = page_sel;
        e_ctrl = en_pre ? ~(4'b0001 << idx) : 4'b1111;
        e_show = en_pre ? model_show(n, mpage, bcd_a, bcd_b, blink_mask) : 7'b1111111;
        e_fd   = en_pre && ((n % PRESCALE) == PRESCALE - 1) && (idx == DIGITS - 1);
        @(posedge clk);
        #1;
        if (en_pre) begin
            if (e_fd) mpage = ps_pre;
            n++;
        end
        vectors++;
        if (ssd_ctrl !== e_ctrl) begin
            miscompares++;
            $display("FAIL %s ssd_ctrl n=%0d: got %b expected %b", tag, n, ssd_ctrl, e_ctrl);
        end
        vectors++;
        if (show !== e_show) begin
            miscompares++;
            $display("FAIL %s show n=%0d: got %b expected %b", tag, n, show, e_show);
        end
        vectors++;
        if (frame_done !== e_fd) begin
            miscompares++;
            $display("FAIL %s frame_done n=%0d: got %b expected %b", tag, n, frame_done, e_fd);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        n     = 0;
        mpage = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (ssd_ctrl !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset ssd_ctrl: got %b expected 1111", ssd_ctrl);
        end
        vectors++;
        if (show !== 7'b1111111) begin
            miscompares++;
            $display("FAIL reset show: got %b expected 1111111", show);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset frame_done: got %b expected 0", frame_done);
        end
        rst   = 1'b0;
        n     = 0;
        mpage = 1'b0;
    endtask

    task automatic test_scan();
        bcd_a = 16'h1234; bcd_b = 16'h0000; page_sel = 1'b0; blink_mask = '0; en = 1'b1;
        repeat (2 * FRAME_CYC) step("scan");
    endtask

    task automatic test_page_switch();
        bcd_b = 16'h5678;
        repeat (6) step("page");
        page_sel = 1'b1;
        repeat (2 * FRAME_CYC) step("page");
    endtask

    task automatic test_blink();
        apply_reset();
        page_sel = 1'b0; bcd_a = 16'h1234; blink_mask = 4'b0001; en = 1'b1;
        repeat (6 * FRAME_CYC) step("blink");
        blink_mask = '0;
    endtask

    task automatic test_dash_lzb();
        bcd_a = 16'h00A0; page_sel = 1'b0;
        repeat (3 * FRAME_CYC) step("dash");
    endtask

    task automatic test_pause();
        int guard;
        bcd_a = 16'h1234;
        guard = 0;
        while (!(((n / PRESCALE) % DIGITS) == 2 && (n % PRESCALE) == 1) && guard < 64) begin
            step("pause_seek");
            guard++;
        end
        vectors++;
        if (guard >= 64) begin
            miscompares++;
            $display("FAIL pause_seek: got guard %0d expected < 64", guard);
        end
        en = 1'b0;
        repeat (10) step("pause_off");
        en = 1'b1;
        repeat (FRAME_CYC + 4) step("pause_resume");
    endtask

    task automatic test_reset_mid();
        int guard;
        bcd_b = 16'h5678; bcd_a = 16'h1234; page_sel = 1'b1;
        guard = 0;
        while (!(mpage == 1'b1 && ((n / PRESCALE) % DIGITS) == 2) && guard < 200) begin
            step("rstmid_seek");
            guard++;
        end
        vectors++;
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL rstmid_seek: got guard %0d expected < 200", guard);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ssd_ctrl !== 4'b1111 || show !== 7'b1111111) begin
            miscompares++;
            $display("FAIL rstmid async: got ctrl %b show %b expected 1111 1111111", ssd_ctrl, show);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (frame_done !== 1'b0 || ssd_ctrl !== 4'b1111) begin
            miscompares++;
            $display("FAIL rstmid hold: got fd %b ctrl %b expected 0 1111", frame_done, ssd_ctrl);
        end
        rst   = 1'b0;
        n     = 0;
        mpage = 1'b0;
        repeat (2 * FRAME_CYC) step("rstmid_after");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < DIGITS; d++) begin
                bcd_a[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                bcd_b[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) page_sel = ~page_sel;
            en = ($urandom_range(0, 9) != 0);
            step("random");
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_page_switch();
        test_blink();
        test_dash_lzb();
        test_pause();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_controller.md
SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter PRESCALE, default 65536, clk cycles per digit slot (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period (>=1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  scan enable; low blanks display and freezes counters.
REQ-007 page_sel  input  1  display page request (0 = page A, 1 = page B).
REQ-008 bcd_a  input  4*DIGITS  page A BCD digits, digit i at [4i+3:4i], digit 0 rightmost.
REQ-009 bcd_b  input  4*DIGITS  page B BCD digits, same packing.
REQ-010 blink_mask  input  DIGITS  bit i set: digit i blinks.
REQ-011 ssd_ctrl  output  DIGITS  active-low digit enables, at most one bit low.
REQ-012 show  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-013 frame_done  output  1  one-cycle pulse on completion of each full scan frame.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 while en=1, wraps to 0; slot tick asserted in the cycle it equals PRESCALE-1.
REQ-015 Scan index increments on slot tick, wrapping DIGITS-1 -> 0.
REQ-016 On tick with index = DIGITS-1: frame_done pulses next cycle, active page latched from page_sel, blink frame counter increments.
REQ-017 page_sel changes SHALL take effect only at frame boundary; no frame mixes pages.
REQ-018 Blink counter counts 0..BLINK_FRAMES-1 per frame, wraps; blink phase toggles on wrap; phase 1 = visible.
REQ-019 show and ssd_ctrl SHALL be registered; each reflects index/page/phase state of the previous cycle (one-cycle latency).
REQ-020 ssd_ctrl = all ones except bit[index] = 0.
REQ-021 Decode 0-9 to standard seven-segment patterns (e.g. 0 = 7'b1000000, 8 = 7'b0000000).
REQ-022 BCD 10-15 SHALL display dash, show = 7'b0111111.
REQ-023 Blinking digit in phase 0: show = 7'b1111111, ssd_ctrl still scans.
REQ-024 en=0: ssd_ctrl = all ones, show = 7'b1111111 from next cycle; prescaler, index, page, blink counters hold; frame_done low.
REQ-025 en rising SHALL resume from held counts without restart.
REQ-026 bcd inputs and blink_mask sampled live each cycle (no latching) except via page latch.

Reset
REQ-027 rst=1 SHALL immediately clear prescaler, index, blink counter, active page (A), frame_done=0.
REQ-028 During reset: ssd_ctrl = all ones, show = 7'b1111111; blink phase = 1 (visible).
REQ-029 Reset asserted mid-frame SHALL abandon frame; first cycle after release displays digit 0 of page_sel latched at reset (page A).

Configuration
REQ-030 Macro SSD_LZB_EN: when defined, leading-zero blanking enabled; undefined, every digit always decoded.
REQ-031 With SSD_LZB_EN: digit i (i>=1) blanks (show = 7'b1111111) if it and all digits above it in active page equal 0; digit 0 never blanked.
REQ-032 Leading-zero test uses active page values in the same cycle as decode; nonzero invalid codes (10-15) count as nonzero.

Verification (DIGITS=4, PRESCALE=4, BLINK_FRAMES=2)
REQ-033 Reset release, en=1, bcd_a=16'h1234 -> ssd_ctrl sequence 1110,1101,1011,0111 every 4 cycles, show = 4,3,2,1 patterns; frame_done pulse after digit 3 slot.
REQ-034 page_sel 0->1 mid-frame, bcd_b=16'h5678 -> page A until frame_done, then 8,7,6,5 patterns.
REQ-035 blink_mask=4'b0001 -> digit 0 blank in frames 3-4, visible frames 1-2 and 5-6; other digits unaffected.
REQ-036 bcd_a=16'h00A0 -> digit 1 dash 7'b0111111; with SSD_LZB_EN digits 3,2 blank, digit 0 shows 0; without, digits 3,2 show 0.
REQ-037 en low 10 cycles mid-slot 2 -> all outputs off; on en high, slot 2 completes remaining prescale count, no frame_done during pause.
REQ-038 rst pulse mid-frame (index 2, page B) -> outputs off asynchronously; after release digit 0 of page A, prescaler from 0.
